// File: rtl/onehot_to_binary_enc_if.sv
// Handshake bundle for onehot_to_binary_enc: one-hot input stream, encoded
// output stream and the error-counter control/status pair.
interface onehot_to_binary_enc_if #(
   parameter int WID         = 4,
   parameter int ONEHOT_WID  = 16,
   parameter int ERR_CNT_WID = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [ONEHOT_WID-1:0]  in_onehot;
   logic                   out_valid;
   logic                   out_ready;
   logic [WID-1:0]         out_bin;
   logic                   out_err;
   logic                   err_clr;
   logic [ERR_CNT_WID-1:0] err_cnt;

   modport master (
      output in_valid, in_onehot, out_ready, err_clr,
      input  in_ready, out_valid, out_bin, out_err, err_cnt
   );

   modport slave (
      input  in_valid, in_onehot, out_ready, err_clr,
      output in_ready, out_valid, out_bin, out_err, err_cnt
   );
endinterface

// File: rtl/onehot_to_binary_enc.sv
// Two-stage registered one-hot to binary encoder with zero/multi-hot
// detection and a saturating count of erroneous words delivered.
module onehot_to_binary_enc #(
   parameter int WID         = 4,
   parameter int ONEHOT_WID  = 16,
   parameter int ERR_CNT_WID = 8
) (
   input logic                   clk,
   input logic                   rst_n,
   onehot_to_binary_enc_if.slave bus
);

   logic                   rdy_en;
   logic                   vld_p1;
   logic [ONEHOT_WID-1:0]  onehot_p1;
   logic                   vld_p2;
   logic [WID-1:0]         bin_p2;
   logic                   err_p2;
   logic [ERR_CNT_WID-1:0] err_cnt_q;

   logic                   s1_load;
   logic                   s2_load;
   logic                   in_xfer;
   logic                   out_xfer;
   logic [WID-1:0]         enc_bin;
   logic                   enc_err;

   // Lowest set bit wins, so multi-hot words still yield a usable index.
   function automatic logic [WID-1:0] lowest_set(input logic [ONEHOT_WID-1:0] v);
      logic [WID-1:0] idx;
      idx = '0;
      for (int i = ONEHOT_WID - 1; i >= 0; i--) begin
         if (v[i]) idx = WID'(i);
      end
      return idx;
   endfunction

   function automatic logic not_onehot(input logic [ONEHOT_WID-1:0] v);
      return ($countones(v) != 1);
   endfunction

   function automatic logic [ERR_CNT_WID-1:0] sat_inc(input logic [ERR_CNT_WID-1:0] c);
      return (&c) ? c : c + ERR_CNT_WID'(1);
   endfunction

   assign s2_load  = ~vld_p2 | bus.out_ready;
   assign s1_load  = ~vld_p1 | s2_load;
   assign in_xfer  = bus.in_valid & bus.in_ready;
   assign out_xfer = vld_p2 & bus.out_ready;
   assign enc_bin  = lowest_set(onehot_p1);
   assign enc_err  = not_onehot(onehot_p1);

   // rdy_en keeps in_ready low during reset and until the first edge after it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en    <= 1'b0;
         vld_p1    <= 1'b0;
         vld_p2    <= 1'b0;
         bin_p2    <= '0;
         err_p2    <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (s1_load) vld_p1 <= in_xfer;
         // ---- p1 -> p2: encode and register the result ----
         if (s2_load) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
               bin_p2 <= enc_bin;
               err_p2 <= enc_err;
            end
         end
         if (bus.err_clr)           err_cnt_q <= '0;
         else if (out_xfer && err_p2) err_cnt_q <= sat_inc(err_cnt_q);
      end
   end

   // ---- p0 -> p1: capture the raw word ----
   always_ff @(posedge clk) begin
      if (in_xfer) onehot_p1 <= bus.in_onehot;
   end

   assign bus.in_ready  = rdy_en & s1_load;
   assign bus.out_valid = vld_p2;
   assign bus.out_bin   = bin_p2;
   assign bus.out_err   = err_p2;
   assign bus.err_cnt   = err_cnt_q;

endmodule
